// File: rtl/crc5_token_ctrl.sv
//==============================================================================
// crc5_token_ctrl : serialises a USB token (PID, ADDR, ENDP, CRC5) using an
//                   external crc5 engine over a start/ready/done handshake.
// Revision: 1.0
//==============================================================================
`default_nettype none

module crc5_token_ctrl #(
  parameter int CRC_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [3:0] pid,
  input  logic [6:0] addr,
  input  logic [3:0] endp,
  output logic       busy,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       done,
  output logic       err,
  output logic       crc_start,
  output logic       crc_s_in,
  input  logic       crc_ready,
  input  logic       crc_done,
  input  logic       crc_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PID   = 3'd1,
    S_FIELD = 3'd2,
    S_WAIT  = 3'd3,
    S_CRC   = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(CRC_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]      pid_q, pid_d;
  logic [6:0]      addr_q, addr_d;
  logic [3:0]      endp_q, endp_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [7:0]      pid_word;
  logic [10:0]     field_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      pid_q     <= '0;
      addr_q    <= '0;
      endp_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      pid_q     <= pid_d;
      addr_q    <= addr_d;
      endp_q    <= endp_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    pid_d     = pid_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go && crc_ready) begin
          pid_d     = pid;
          addr_d    = addr;
          endp_d    = endp;
          bit_cnt_d = '0;
          state_d   = S_PID;
        end
      end
      S_PID: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd7) begin
          bit_cnt_d = '0;
          state_d   = S_FIELD;
        end
      end
      S_FIELD: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // A done arriving on the final timeout cycle still wins.
        if (crc_done) begin
          bit_cnt_d = '0;
          state_d   = S_CRC;
        end else if (to_cnt_q == C_TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CRC: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd4) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pid_word   = {~pid_q, pid_q};
  assign field_word = {endp_q, addr_q};

  always_comb begin
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    crc_start = 1'b0;
    crc_s_in  = 1'b0;
    case (state_q)
      S_PID: begin
        bit_out   = pid_word[bit_cnt_q[2:0]];
        bit_valid = 1'b1;
        crc_start = (bit_cnt_q == 4'd7);
      end
      S_FIELD: begin
        bit_out   = field_word[bit_cnt_q];
        bit_valid = 1'b1;
        crc_s_in  = field_word[bit_cnt_q];
      end
      S_CRC: begin
        bit_out   = crc_out;
        bit_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_crc5_token_ctrl.sv
//==============================================================================
// tb_crc5_token_ctrl : directed self-checking bench for crc5_token_ctrl.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_crc5_token_ctrl;

  localparam int T = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [3:0] pid;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       busy, bit_out, bit_valid, done, err, crc_start, crc_s_in;
  logic       crc_ready, crc_done, crc_out;

  int n_pass = 0;
  int n_total = 0;

  crc5_token_ctrl #(.CRC_TIMEOUT(T), .TO_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .pid       (pid),
    .addr      (addr),
    .endp      (endp),
    .busy      (busy),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .done      (done),
    .err       (err),
    .crc_start (crc_start),
    .crc_s_in  (crc_s_in),
    .crc_ready (crc_ready),
    .crc_done  (crc_done),
    .crc_out   (crc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present a request in the current IDLE cycle; return in PID cycle 1.
  task automatic accept(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
    pid = p; addr = a; endp = e; go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // Check cycles 1..19; xp/xf are written first-bit-leftmost.
  task automatic stream(input logic [7:0] xp, input logic [10:0] xf, input bit scramble);
    for (int i = 0; i < 8; i++) begin
      chk("pid_bit", {7'd0, bit_out}, {7'd0, xp[7-i]});
      chk("pid_valid", {7'd0, bit_valid}, 8'd1);
      chk("pid_start", {7'd0, crc_start}, {7'd0, (i == 7)});
      chk("pid_sin", {7'd0, crc_s_in}, 8'd0);
      chk("pid_busy", {7'd0, busy}, 8'd1);
      if (scramble) begin
        pid = 4'($urandom); addr = 7'($urandom); endp = 4'($urandom); go = 1'b1;
      end
      tick();
    end
    for (int i = 0; i < 11; i++) begin
      chk("fld_bit", {7'd0, bit_out}, {7'd0, xf[10-i]});
      chk("fld_sin", {7'd0, crc_s_in}, {7'd0, xf[10-i]});
      chk("fld_valid", {7'd0, bit_valid}, 8'd1);
      chk("fld_start", {7'd0, crc_start}, 8'd0);
      if (scramble) begin
        pid = 4'($urandom); addr = 7'($urandom); endp = 4'($urandom); go = 1'b1;
      end
      tick();
    end
    go = 1'b0;
  endtask

  // WAIT_CRC with crc_done in wait cycle dly, then 5 CRC bits MSB first.
  task automatic crc_phase(input int dly, input logic [4:0] crc);
    for (int k = 0; k < dly; k++) begin
      chk("wait_valid", {7'd0, bit_valid}, 8'd0);
      chk("wait_busy", {7'd0, busy}, 8'd1);
      chk("wait_err", {7'd0, err}, 8'd0);
      tick();
    end
    crc_done = 1'b1;
    chk("wait_sin", {7'd0, crc_s_in}, 8'd0);
    tick();
    crc_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      crc_out = crc[4-i];
      #1;
      chk("crc_bit", {7'd0, bit_out}, {7'd0, crc[4-i]});
      chk("crc_valid", {7'd0, bit_valid}, 8'd1);
      chk("crc_err", {7'd0, err}, 8'd0);
      chk("crc_done_early", {7'd0, done}, 8'd0);
      tick();
    end
    crc_out = 1'b0;
    chk("done_pulse", {7'd0, done}, 8'd1);
    chk("done_busy", {7'd0, busy}, 8'd0);
    chk("done_err", {7'd0, err}, 8'd0);
    chk("done_valid", {7'd0, bit_valid}, 8'd0);
    tick();
    chk("done_single", {7'd0, done}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; pid = '0; addr = '0; endp = '0;
    crc_ready = 1'b1; crc_done = 1'b0; crc_out = 1'b0;
    #12;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_outs", {1'b0, bit_out, bit_valid, done, err, crc_start, crc_s_in, 1'b0}, 8'd0);
    rst = 1'b0;
    tick();

    // OUT token, crc_done two cycles after the last field bit.
    accept(4'b0001, 7'h3A, 4'hA);
    stream(8'b1000_0111, 11'b0101110_0101, 1'b0);
    crc_phase(1, 5'b10110);

    // go with crc_ready low is ignored.
    crc_ready = 1'b0; go = 1'b1;
    tick();
    chk("nordy_busy", {7'd0, busy}, 8'd0);
    chk("nordy_start", {7'd0, crc_start}, 8'd0);
    tick();
    chk("nordy_busy2", {7'd0, busy}, 8'd0);
    go = 1'b0; crc_ready = 1'b1;

    // IN token, inputs scrambled and go held high throughout.
    accept(4'b1001, 7'h05, 4'h1);
    stream(8'b1001_0110, 11'b1010000_1000, 1'b1);
    crc_phase(3, 5'b01101);

    // Timeout: no crc_done at all.
    accept(4'b0001, 7'h3A, 4'hA);
    stream(8'b1000_0111, 11'b0101110_0101, 1'b0);
    for (int k = 0; k < T; k++) begin
      chk("to_wait_err", {7'd0, err}, 8'd0);
      chk("to_wait_busy", {7'd0, busy}, 8'd1);
      chk("to_wait_valid", {7'd0, bit_valid}, 8'd0);
      tick();
    end
    chk("to_err", {7'd0, err}, 8'd1);
    chk("to_done", {7'd0, done}, 8'd0);
    chk("to_busy", {7'd0, busy}, 8'd0);

    // Immediate re-accept, then crc_done on the last timeout count.
    accept(4'b0101, 7'h7F, 4'h0);
    chk("reacc_busy", {7'd0, busy}, 8'd1);
    chk("reacc_err", {7'd0, err}, 8'd0);
    stream(8'b1010_0101, 11'b1111111_0000, 1'b0);
    crc_phase(T - 1, 5'b11001);

    // Reset in cycle 12 (field bit 4).
    accept(4'b0001, 7'h3A, 4'hA);
    for (int c = 1; c < 12; c++) tick();
    chk("pre_rst_valid", {7'd0, bit_valid}, 8'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_outs", {1'b0, bit_out, bit_valid, done, err, crc_start, crc_s_in, 1'b0}, 8'd0);
    tick();
    chk("mid_rst_hold", {6'd0, done, err}, 8'd0);
    rst = 1'b0;
    tick();
    chk("post_rst", {5'd0, busy, done, err}, 8'd0);

    accept(4'b0001, 7'h3A, 4'hA);
    stream(8'b1000_0111, 11'b0101110_0101, 1'b0);
    crc_phase(1, 5'b10110);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/crc5_token_ctrl.md
Name: crc5_token_ctrl

Overview:
Sequences a USB token packet (PID, ADDR, ENDP, CRC5) onto a serial bit stream, driving the shared crc5 engine over its start/ready/done handshake. Sits between the packet-layer request logic and the bit-level transmit path (bit stuffer / NRZI). It latches a token request, emits the PID byte directly, and streams the 11 ADDR/ENDP bits to both the output and the crc5 serial input. It then forwards the 5 CRC bits returned by the engine and reports completion or timeout.

Parameters:
CRC_TIMEOUT, 15, max cycles to wait for crc_done after the last field bit before aborting
TO_W, 4, width of the timeout counter (must satisfy 2**TO_W > CRC_TIMEOUT)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
go  input  1  token request; accepted only when busy=0 and crc_ready=1
pid  input  4  token PID nibble
addr  input  7  device address
endp  input  4  endpoint number
busy  output  1  high from accept until return to IDLE
bit_out  output  1  serial token bit
bit_valid  output  1  bit_out is meaningful this cycle
done  output  1  one-cycle pulse, token sent successfully
err  output  1  one-cycle pulse, CRC timeout abort
crc_start  output  1  one-cycle start pulse to crc5
crc_s_in  output  1  serial data to crc5
crc_ready  input  1  crc5 idle and able to start
crc_done  input  1  crc5 one-cycle pulse; CRC bits follow on crc_out
crc_out  input  1  serial CRC bit from crc5

Behaviour:
- Reset: state IDLE. busy, bit_out, bit_valid, done, err, crc_start, crc_s_in = 0. Counters cleared. Reset mid-packet aborts immediately with no done or err.
- Accept: in IDLE with go=1 and crc_ready=1, latch pid/addr/endp into shadow registers and go to SEND_PID next cycle. go is ignored while busy or while crc_ready=0.
- States: IDLE, SEND_PID, SEND_FIELD, WAIT_CRC, SEND_CRC.
- SEND_PID: 8 cycles, bit_valid=1. Bits in order: pid[0..3], then ~pid[0..3]. crc_start=1 only in the 8th PID cycle. Then go to SEND_FIELD.
- SEND_FIELD: 11 cycles, bit_valid=1. Order: addr[0..6], then endp[0..3]. crc_s_in = bit_out in each of these cycles. crc_s_in=0 in all other states. Then go to WAIT_CRC.
- WAIT_CRC: bit_valid=0. Timeout counter cleared on entry and increments each cycle.
  - crc_done=1: go to SEND_CRC.
  - Count reaches CRC_TIMEOUT with no done: pulse err, go to IDLE.
  - crc_done in the same cycle the count expires: done wins, no err.
- SEND_CRC: 5 cycles, bit_out = crc_out, bit_valid=1. On leaving, pulse done (the cycle after the last CRC bit) and go to IDLE. busy drops in the same cycle as done.
- Timeline from the accept edge: cycles 1-8 PID, 9-19 field, WAIT_CRC from 20, and 5 CRC bits starting the cycle after crc_done.
- crc_done outside WAIT_CRC is ignored. crc_ready is sampled only at accept.
- Downstream never stalls: every bit_valid=1 cycle is consumed. Gaps in bit_valid are permitted only in WAIT_CRC.
- Shadow registers hold the latched request for the whole packet. Input changes after accept have no effect.

Test Plan:
- OUT token, pid=4'b0001, addr=7'h3A, endp=4'hA; crc stub asserts crc_done 2 cycles after the last field bit, then drives 5'b10110 MSB first -> stream 1000 0111 | 0101110 | 0101 | 1,0,1,1,0. crc_start high only in cycle 8. crc_s_in matches cycles 9-19. done pulses once, busy low afterwards.
- crc stub never asserts crc_done -> err pulses exactly CRC_TIMEOUT cycles after entering WAIT_CRC, with no CRC bits and no done. A new go is accepted the next cycle.
- go while busy and go with crc_ready=0 -> both ignored: busy stays as is, no crc_start, stream unaffected.
- Change pid/addr/endp every cycle during a packet -> emitted stream equals the values latched at accept.
- Assert rst at cycle 12 (mid field) -> all outputs 0 immediately, no done or err. A fresh token after reset is correct bit-for-bit.
- crc_done coinciding with the final timeout count -> SEND_CRC entered, done pulses, err never asserts.
